// File: rtl/spike_rate_encoder_if.sv
// Handshake and data bundle between a pixel source and the spike rate encoder.
// master drives start/pix; slave (the encoder) returns the spike train and window totals.
interface spike_rate_encoder_if #(
   parameter int N_CH    = 2,
   parameter int PIX_W   = 8,
   parameter int WIN_LEN = 16,
   parameter int CNT_W   = $clog2(WIN_LEN + 1)
);
   localparam int SW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

   logic                    start;
   logic [N_CH*PIX_W-1:0]   pix;
   logic                    busy;
   logic                    x_valid;
   logic [N_CH-1:0]         x_spike;
   logic [SW-1:0]           step_idx;
   logic                    done;
   logic [N_CH*CNT_W-1:0]   spike_count;

   modport master (
      output start, pix,
      input  busy, x_valid, x_spike, step_idx, done, spike_count
   );

   modport slave (
      input  start, pix,
      output busy, x_valid, x_spike, step_idx, done, spike_count
   );
endinterface

// File: rtl/spike_rate_encoder.sv
// Bernoulli rate encoder: per-channel intensities become spike trains over a fixed
// window, driven by a 16-bit LFSR reseeded on every accepted start.
module spike_rate_encoder #(
   parameter int          N_CH      = 2,
   parameter int          PIX_W     = 8,
   parameter int          WIN_LEN   = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          CNT_W     = $clog2(WIN_LEN + 1)
) (
   input logic                 clk,
   input logic                 reset,
   spike_rate_encoder_if.slave bus
);
   localparam int SW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [15:0]             lfsr;
   logic [N_CH*PIX_W-1:0]   pix_q;
   logic [SW-1:0]           k;
   logic [N_CH-1:0]         spike;
   logic                    busy_q;
   logic                    x_valid_q;
   logic                    done_q;
   logic [N_CH-1:0]         x_spike_q;
   logic [SW-1:0]           step_q;
   logic [N_CH*CNT_W-1:0]   cnt_q;

   // Full-scale intensity forces a spike, since rnd < all-ones misses rnd == all-ones.
   always_comb begin
      spike = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         spike[c] = (lfsr[c*PIX_W +: PIX_W] < pix_q[c*PIX_W +: PIX_W]) ||
                    (pix_q[c*PIX_W +: PIX_W] == '1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lfsr      <= LFSR_SEED;
         pix_q     <= '0;
         k         <= '0;
         busy_q    <= 1'b0;
         x_valid_q <= 1'b0;
         x_spike_q <= '0;
         step_q    <= '0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done_q    <= 1'b0;
               x_valid_q <= 1'b0;
               x_spike_q <= '0;
               busy_q    <= bus.start;
               if (bus.start) begin
                  pix_q <= bus.pix;
                  lfsr  <= LFSR_SEED;
                  cnt_q <= '0;
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               x_valid_q <= 1'b1;
               x_spike_q <= spike;
               step_q    <= k;
               k         <= k + SW'(1);
               lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
               for (int unsigned c = 0; c < N_CH; c++) begin
                  cnt_q[c*CNT_W +: CNT_W] <= cnt_q[c*CNT_W +: CNT_W] + CNT_W'(spike[c]);
               end
               if (k == SW'(WIN_LEN - 1)) state <= DONE;
            end
            DONE: begin
               x_valid_q <= 1'b0;
               x_spike_q <= '0;
               done_q    <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.x_valid     = x_valid_q;
   assign bus.x_spike     = x_spike_q;
   assign bus.step_idx    = step_q;
   assign bus.done        = done_q;
   assign bus.spike_count = cnt_q;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder (N_CH=2, PIX_W=8, WIN_LEN=16, seed ACE1).
module tb_spike_rate_encoder;
   logic clk = 1'b0;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   spike_rate_encoder_if #(.N_CH(2), .PIX_W(8), .WIN_LEN(16)) bus ();

   spike_rate_encoder #(
      .N_CH(2), .PIX_W(8), .WIN_LEN(16), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // Samples taken at successive negedges; index 0 follows the acceptance edge.
   logic       c_busy  [64];
   logic       c_valid [64];
   logic       c_done  [64];
   logic [1:0] c_spk   [64];
   logic [3:0] c_idx   [64];
   logic [9:0] c_cnt   [64];

   function automatic logic [15:0] lfsr_after(input int n);
      logic [15:0] l;
      l = 16'hACE1;
      for (int j = 0; j < n; j++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      return l;
   endfunction

   function automatic logic [1:0] exp_spk(input logic [15:0] p, input int step);
      logic [15:0] l;
      logic [7:0]  rnd, pc;
      logic [1:0]  s;
      l = lfsr_after(step);
      for (int c = 0; c < 2; c++) begin
         rnd  = l[c*8 +: 8];
         pc   = p[c*8 +: 8];
         s[c] = (rnd < pc) || (pc == 8'hFF);
      end
      return s;
   endfunction

   function automatic logic [9:0] exp_count(input logic [15:0] p);
      int n0, n1;
      logic [1:0] s;
      n0 = 0; n1 = 0;
      for (int k = 0; k < 16; k++) begin
         s = exp_spk(p, k);
         n0 += int'(s[0]);
         n1 += int'(s[1]);
      end
      return {5'(n1), 5'(n0)};
   endfunction

   // Expected {busy, x_valid, done, x_spike, step_idx} r samples after acceptance.
   function automatic logic [8:0] exp_tuple(input int r, input logic [15:0] p);
      if (r == 0)       return {3'b100, 2'b00, 4'd0};
      else if (r <= 16) return {3'b110, exp_spk(p, r - 1), 4'(r - 1)};
      else if (r == 17) return {3'b101, 2'b00, 4'd0};
      else              return 9'd0;
   endfunction

   function automatic logic [8:0] got_tuple(input int i);
      return {c_busy[i], c_valid[i], c_done[i], c_spk[i], c_valid[i] ? c_idx[i] : 4'd0};
   endfunction

   task automatic start_window(input logic [15:0] p);
      @(negedge clk);
      bus.start = 1'b1;
      bus.pix   = p;
   endtask

   task automatic capture(input int ncyc, input bit hold, input int poke_i,
                          input logic [15:0] poke_pix, input int rst_i);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         c_busy[i]  = bus.busy;
         c_valid[i] = bus.x_valid;
         c_done[i]  = bus.done;
         c_spk[i]   = bus.x_spike;
         c_idx[i]   = bus.step_idx;
         c_cnt[i]   = bus.spike_count;
         bus.start  = hold;
         if (i == poke_i) begin
            bus.start = 1'b1;
            bus.pix   = poke_pix;
         end
         reset = (i == rst_i);
      end
   endtask

   task automatic test_reset;
      logic [19:0] all;
      bus.start = 1'b0;
      bus.pix   = '0;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      all = {bus.busy, bus.x_valid, bus.done, bus.x_spike, bus.step_idx, bus.spike_count};
      vecs++;
      if (all !== 20'd0) begin
         errs++; $display("FAIL reset_outputs got=%h exp=0", all);
      end
      bus.start = 1'b1;
      @(negedge clk);
      vecs++;
      if (bus.busy !== 1'b0) begin
         errs++; $display("FAIL reset_beats_start got busy=%b exp=0", bus.busy);
      end
      reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      vecs++;
      if (bus.busy !== 1'b0) begin
         errs++; $display("FAIL idle_after_reset got busy=%b exp=0", bus.busy);
      end
   endtask

   task automatic test_extremes;
      logic [15:0] p;
      p = {8'd255, 8'd0};
      start_window(p);
      capture(20, 1'b0, -1, '0, -1);
      for (int i = 1; i <= 16; i++) begin
         vecs++;
         if (c_valid[i] !== 1'b1 || c_spk[i] !== 2'b10) begin
            errs++; $display("FAIL extremes_spike i=%0d got v=%b s=%b exp v=1 s=10", i, c_valid[i], c_spk[i]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         vecs++;
         if (got_tuple(i) !== exp_tuple(i, p)) begin
            errs++; $display("FAIL extremes_timing i=%0d got=%h exp=%h", i, got_tuple(i), exp_tuple(i, p));
         end
      end
      vecs++;
      if (c_cnt[17] !== {5'd16, 5'd0}) begin
         errs++; $display("FAIL extremes_count got=%h exp=%h", c_cnt[17], {5'd16, 5'd0});
      end
      vecs++;
      if (c_cnt[19] !== {5'd16, 5'd0}) begin
         errs++; $display("FAIL extremes_count_held got=%h exp=%h", c_cnt[19], {5'd16, 5'd0});
      end
   endtask

   task automatic test_model;
      logic [15:0] p;
      p = {8'd64, 8'd128};
      start_window(p);
      capture(20, 1'b0, -1, '0, -1);
      for (int i = 0; i < 20; i++) begin
         vecs++;
         if (got_tuple(i) !== exp_tuple(i, p)) begin
            errs++; $display("FAIL model_step i=%0d got=%h exp=%h", i, got_tuple(i), exp_tuple(i, p));
         end
      end
      vecs++;
      if (c_cnt[17] !== exp_count(p)) begin
         errs++; $display("FAIL model_count got=%h exp=%h", c_cnt[17], exp_count(p));
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] p;
      p = {8'd200, 8'd37};
      start_window(p);
      capture(38, 1'b0, 17, p, -1);
      for (int i = 0; i < 38; i++) begin
         vecs++;
         if (got_tuple(i) !== exp_tuple(i < 18 ? i : i - 18, p)) begin
            errs++; $display("FAIL b2b_step i=%0d got=%h exp=%h", i, got_tuple(i), exp_tuple(i < 18 ? i : i - 18, p));
         end
      end
      for (int i = 1; i <= 16; i++) begin
         vecs++;
         if (c_spk[i + 18] !== c_spk[i]) begin
            errs++; $display("FAIL b2b_reseed i=%0d got=%b exp=%b", i, c_spk[i + 18], c_spk[i]);
         end
      end
      vecs++;
      if (c_cnt[18] !== 10'd0) begin
         errs++; $display("FAIL b2b_count_clear got=%h exp=0", c_cnt[18]);
      end
      vecs++;
      if (c_cnt[35] !== exp_count(p)) begin
         errs++; $display("FAIL b2b_count got=%h exp=%h", c_cnt[35], exp_count(p));
      end
   endtask

   task automatic test_start_ignored;
      logic [15:0] p;
      p = {8'd90, 8'd170};
      start_window(p);
      capture(24, 1'b0, 6, 16'hFFFF, -1);
      for (int i = 0; i < 24; i++) begin
         vecs++;
         if (got_tuple(i) !== exp_tuple(i, p)) begin
            errs++; $display("FAIL ignored_start i=%0d got=%h exp=%h", i, got_tuple(i), exp_tuple(i, p));
         end
      end
      vecs++;
      if (c_cnt[17] !== exp_count(p)) begin
         errs++; $display("FAIL ignored_count got=%h exp=%h", c_cnt[17], exp_count(p));
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] p;
      int seen_done;
      p = {8'd64, 8'd128};
      start_window(p);
      capture(26, 1'b0, -1, '0, 8);
      for (int i = 0; i <= 8; i++) begin
         vecs++;
         if (got_tuple(i) !== exp_tuple(i, p)) begin
            errs++; $display("FAIL rstmid_pre i=%0d got=%h exp=%h", i, got_tuple(i), exp_tuple(i, p));
         end
      end
      vecs++;
      if ({c_busy[9], c_valid[9], c_done[9], c_spk[9], c_idx[9], c_cnt[9]} !== 19'd0) begin
         errs++; $display("FAIL rstmid_clear got b=%b v=%b d=%b s=%b idx=%0d cnt=%h exp all 0",
                          c_busy[9], c_valid[9], c_done[9], c_spk[9], c_idx[9], c_cnt[9]);
      end
      seen_done = 0;
      for (int i = 9; i < 26; i++) seen_done += int'(c_done[i]) + int'(c_busy[i]);
      vecs++;
      if (seen_done !== 0) begin
         errs++; $display("FAIL rstmid_no_done got busy/done samples=%0d exp=0", seen_done);
      end
      start_window(p);
      capture(20, 1'b0, -1, '0, -1);
      for (int i = 0; i < 20; i++) begin
         vecs++;
         if (got_tuple(i) !== exp_tuple(i, p)) begin
            errs++; $display("FAIL rstmid_restart i=%0d got=%h exp=%h", i, got_tuple(i), exp_tuple(i, p));
         end
      end
      vecs++;
      if (c_cnt[17] !== exp_count(p)) begin
         errs++; $display("FAIL rstmid_count got=%h exp=%h", c_cnt[17], exp_count(p));
      end
   endtask

   task automatic test_hold_start;
      logic [15:0] p;
      p = {8'd10, 8'd240};
      start_window(p);
      capture(54, 1'b1, -1, '0, -1);
      for (int i = 0; i < 54; i++) begin
         vecs++;
         if (got_tuple(i) !== exp_tuple(i % 18, p)) begin
            errs++; $display("FAIL hold_step i=%0d got=%h exp=%h", i, got_tuple(i), exp_tuple(i % 18, p));
         end
      end
      for (int i = 0; i < 36; i++) begin
         vecs++;
         if (c_spk[i + 18] !== c_spk[i]) begin
            errs++; $display("FAIL hold_repeat i=%0d got=%b exp=%b", i, c_spk[i + 18], c_spk[i]);
         end
      end
      bus.start = 1'b0;
      repeat (24) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.pix   = '0;
      test_reset;
      test_extremes;
      test_model;
      test_back_to_back;
      test_start_ignored;
      test_reset_mid;
      test_hold_start;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Upstream stage of the LIF neuron. Converts N_CH pixel intensities into per-timestep Bernoulli spike trains (x1/x2 inputs of the neuron) over a fixed window of WIN_LEN timesteps.
- Randomness comes from one 16-bit LFSR, reseeded on every start, so each window is reproducible.
- A start/busy/done handshake frames each window. Per-channel spike totals are reported at window end for checking and readout.

Parameters:
- N_CH, 2, number of input channels/spike outputs; N_CH*PIX_W must be <= 16.
- PIX_W, 8, intensity width per channel.
- WIN_LEN, 16, timesteps per encoding window (>= 1).
- LFSR_SEED, 16'hACE1, LFSR load value on reset and on every accepted start; must be nonzero.
- CNT_W, $clog2(WIN_LEN+1), width of each spike counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a window; sampled only in IDLE.
- pix  in  N_CH*PIX_W  intensities; channel c = pix[c*PIX_W +: PIX_W]; sampled with start.
- busy  out  1  high in RUN and DONE.
- x_valid  out  1  high for exactly WIN_LEN consecutive cycles per window.
- x_spike  out  N_CH  spike vector for the current timestep; bit0->x1, bit1->x2 of the neuron.
- step_idx  out  $clog2(WIN_LEN)  (min 1)  timestep index of the current x_spike.
- done  out  1  one-cycle pulse after the last timestep.
- spike_count  out  N_CH*CNT_W  per-channel spikes emitted in the last window; held until the next start.

Behaviour:
- All outputs are registered. On reset at a clk edge:
  - state=IDLE, lfsr=LFSR_SEED.
  - busy=0, x_valid=0, x_spike=0, step_idx=0, done=0, spike_count=0.
  - Reset wins over any simultaneous start, including mid-window: no done is issued and spike_count clears.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shift left; new bit0 = l[15]^l[13]^l[12]^l[10].
  - Advances once per RUN cycle only.
- Spike rule for channel c at each RUN edge:
  - Let rnd_c = lfsr[c*PIX_W +: PIX_W] (value before advance) and p = latched pix for channel c.
  - spike = (rnd_c < p) OR (p == all-ones).
  - p=0 never spikes; p=max always spikes.
- FSM:
  - IDLE: done=0, busy=0, x_valid=0. If start=1 at the edge:
    - Latch pix, load lfsr=LFSR_SEED, clear spike_count and step counter.
    - Go to RUN; busy=1 after this edge.
  - RUN: each edge:
    - x_valid<=1, x_spike<=spike vector, step_idx<=k, where k = number of prior RUN edges in this window.
    - spike_count[c] += spike bit; lfsr advances.
    - At the edge where k=WIN_LEN-1, go to DONE.
  - DONE (1 cycle):
    - x_valid<=0, x_spike<=0, done<=1, busy stays 1.
    - Next edge goes to IDLE with done<=0 and busy<=0.
- Timing: with start sampled at edge T:
  - x_valid is high after edges T+1..T+WIN_LEN.
  - done is high after edge T+WIN_LEN+1.
  - A new start is accepted at edge T+WIN_LEN+2 at the earliest.
- start in RUN/DONE is ignored and not queued. pix changes after acceptance have no effect.
- spike_count saturation is impossible: max value is WIN_LEN, which fits CNT_W.
- x_spike is 0 whenever x_valid=0.

Test Plan:
- Reset, then start with pix0=0, pix1=255, WIN_LEN=16 -> x_valid high 16 cycles; x_spike[0] always 0, x_spike[1] always 1; done pulses 1 cycle later; spike_count = {16,0} (ch1,ch0).
- Start with pix0=128, pix1=64 -> per-step spikes match a reference model of the LFSR rule from seed 16'hACE1; final counts match the model; step_idx runs 0..15.
- Run two back-to-back windows with identical pix -> identical x_spike sequences (reseed check); second start accepted exactly 2 cycles after the last x_valid.
- Pulse start at step 5 of a window with different pix -> no effect on the current train, no second window, busy/done timing unchanged.
- Assert reset at step 7 -> next cycle busy=0, x_valid=0, spike_count=0, no done pulse; a subsequent start reproduces the seed-ACE1 sequence from step 0.
- Hold start=1 continuously -> windows repeat with exactly one idle cycle between each done and the next window's acceptance edge; every window is identical.
